// File: rtl/wb_commit_queue.sv
// Writeback commit queue: compacts live writing lanes into an in-order ring and retires
// up to RF_PORTS entries per cycle. Optional macro: WB_SAME_DEST_FILTER_EN (same-dest filter).
module wb_commit_queue #(
    parameter int LANES    = 2,
    parameter int RF_PORTS = 2,
    parameter int DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ws_ready,
    input  logic [2*LANES-1:0]     es_to_ws_valid,
    input  logic [70*LANES-1:0]    es_to_ws_bus,
    output logic [70*RF_PORTS-1:0] ws_to_rf_bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t LANES_C = cnt_t'(LANES);
    localparam cnt_t PORTS_C = cnt_t'(RF_PORTS);

    function automatic cnt_t min_cnt(input cnt_t a, input cnt_t b);
        cnt_t r;
        if (a < b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    logic [31:0] pc_mem_r   [DEPTH];
    logic [4:0]  dest_mem_r [DEPTH];
    logic [31:0] data_mem_r [DEPTH];
    logic [31:0] pc_nxt_s   [DEPTH];
    logic [4:0]  dest_nxt_s [DEPTH];
    logic [31:0] data_nxt_s [DEPTH];

    ptr_t head_r;
    ptr_t tail_r;
    cnt_t count_r;
    logic ws_ready_r;
    logic [70*RF_PORTS-1:0] bus_r;

    ptr_t head_nxt_s;
    ptr_t tail_nxt_s;
    cnt_t count_nxt_s;
    cnt_t enq_s;
    cnt_t deq_s;
    cnt_t pres_nxt_s;
    ptr_t wr_idx_s;
    ptr_t rd_idx_s [RF_PORTS];
    logic [LANES-1:0]       lane_eff_s;
    logic [RF_PORTS-1:0]    pres_s;
    logic [RF_PORTS-1:0]    we_s;
    logic [70*RF_PORTS-1:0] bus_nxt_s;

    // Per-lane effective write: live, writing, and not targeting r0
    always_comb begin
        lane_eff_s = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_eff_s[i] = es_to_ws_valid[2*i+1] & es_to_ws_valid[2*i]
                          & es_to_ws_bus[70*i+69]
                          & (es_to_ws_bus[70*i+64 +: 5] != 5'd0);
        end
    end

    // Compacted enqueue of effective writes into consecutive slots from the tail
    always_comb begin
        pc_nxt_s   = pc_mem_r;
        dest_nxt_s = dest_mem_r;
        data_nxt_s = data_mem_r;
        enq_s      = '0;
        wr_idx_s   = tail_r;
        for (int i = 0; i < LANES; i++) begin
            if (ws_ready_r && lane_eff_s[i]) begin
                wr_idx_s             = tail_r + ptr_t'(enq_s);
                pc_nxt_s[wr_idx_s]   = es_to_ws_bus[70*i +: 32];
                data_nxt_s[wr_idx_s] = es_to_ws_bus[70*i+32 +: 32];
                dest_nxt_s[wr_idx_s] = es_to_ws_bus[70*i+64 +: 5];
                enq_s                = enq_s + cnt_t'(1);
            end else begin
                enq_s = enq_s;
            end
        end
    end

    // Pointer and occupancy bookkeeping; retire uses the current count only
    always_comb begin
        deq_s       = min_cnt(count_r, PORTS_C);
        head_nxt_s  = head_r + ptr_t'(deq_s);
        tail_nxt_s  = tail_r + ptr_t'(enq_s);
        count_nxt_s = count_r + enq_s - deq_s;
        pres_nxt_s  = min_cnt(count_nxt_s, PORTS_C);
    end

    // Next presentation on the RF ports, oldest entry on port 0 (MS slice)
    always_comb begin
        bus_nxt_s = '0;
        pres_s    = '0;
        for (int p = 0; p < RF_PORTS; p++) begin
            rd_idx_s[p] = head_nxt_s + ptr_t'(p);
            pres_s[p]   = (cnt_t'(p) < pres_nxt_s);
        end
        we_s = pres_s;
`ifdef WB_SAME_DEST_FILTER_EN
        // A younger presented write to the same register shadows the older one
        for (int j = 0; j < RF_PORTS; j++) begin
            for (int k = j + 1; k < RF_PORTS; k++) begin
                if (pres_s[k] && (dest_nxt_s[rd_idx_s[k]] == dest_nxt_s[rd_idx_s[j]])) begin
                    we_s[j] = 1'b0;
                end else begin
                    we_s[j] = we_s[j];
                end
            end
        end
`endif
        for (int p = 0; p < RF_PORTS; p++) begin
            bus_nxt_s[70*(RF_PORTS-1-p) +: 70] = {pc_nxt_s[rd_idx_s[p]], we_s[p],
                                                  dest_nxt_s[rd_idx_s[p]],
                                                  data_nxt_s[rd_idx_s[p]]};
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            ws_ready_r <= 1'b1;
            bus_r      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= 32'd0;
                dest_mem_r[i] <= 5'd0;
                data_mem_r[i] <= 32'd0;
            end
        end else begin
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            count_r    <= count_nxt_s;
            ws_ready_r <= ((DEPTH_C - count_nxt_s) >= LANES_C);
            bus_r      <= bus_nxt_s;
            pc_mem_r   <= pc_nxt_s;
            dest_mem_r <= dest_nxt_s;
            data_mem_r <= data_nxt_s;
        end
    end

    assign ws_ready     = ws_ready_r;
    assign ws_to_rf_bus = bus_r;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Scoreboard bench for wb_commit_queue: a 2-port and a 1-port instance share stimulus and are
// checked against a queue-level reference model.
module tb_wb_commit_queue;
    localparam int LANES = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] data;
    } entry_t;

    typedef struct packed {
        logic         rdy0;
        logic         rdy1;
        logic [139:0] bus0;
        logic [139:0] bus1;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   es_to_ws_valid = 4'd0;
    logic [139:0] es_to_ws_bus = 140'd0;
    logic         rdy0;
    logic         rdy1;
    logic [139:0] bus0;
    logic [69:0]  bus1;

    entry_t mq0[$];
    entry_t mq1[$];
    entry_t wq[$];
    exp_t   exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    logic   acc0;
    logic   acc1 = 1'b1;

    always #5 clk = ~clk;

    wb_commit_queue #(.LANES(2), .RF_PORTS(2), .DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .ws_ready(rdy0),
        .es_to_ws_valid(es_to_ws_valid), .es_to_ws_bus(es_to_ws_bus), .ws_to_rf_bus(bus0));

    wb_commit_queue #(.LANES(2), .RF_PORTS(1), .DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .ws_ready(rdy1),
        .es_to_ws_valid(es_to_ws_valid), .es_to_ws_bus(es_to_ws_bus), .ws_to_rf_bus(bus1));

    function automatic logic [69:0] mk(input logic we, input logic [4:0] dest,
                                       input logic [31:0] data, input logic [31:0] pc);
        return {we, dest, data, pc};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_bus(input string name, input int ports,
                             input logic [139:0] act, input logic [139:0] exp);
        int off;
        for (int p = 0; p < ports; p++) begin
            off = 70 * (ports - 1 - p);
            vectors++;
            if ((act[off+37] !== exp[off+37]) ||
                (exp[off+37] && (act[off +: 70] !== exp[off +: 70]))) begin
                miscompares++;
                $display("FAIL %s port%0d at %0t: got %h expected %h (we bit %0b vs %0b)",
                         name, p, $time, act[off +: 70], exp[off +: 70], act[off+37], exp[off+37]);
            end
        end
    endtask

    // Queue-level model of one instance working on wq for one clock edge
    task automatic model_step(input int ports, output logic acc,
                              output logic rdy_after, output logic [139:0] ebus);
        int n;
        entry_t e;
        acc = ((DEPTH - wq.size()) >= LANES);
        n = (wq.size() < ports) ? wq.size() : ports;
        for (int i = 0; i < n; i++) void'(wq.pop_front());
        if (acc) begin
            for (int l = 0; l < LANES; l++) begin
                if (es_to_ws_valid[2*l +: 2] == 2'b11 && es_to_ws_bus[70*l+69] &&
                    es_to_ws_bus[70*l+64 +: 5] != 5'd0) begin
                    e.pc   = es_to_ws_bus[70*l +: 32];
                    e.data = es_to_ws_bus[70*l+32 +: 32];
                    e.dest = es_to_ws_bus[70*l+64 +: 5];
                    wq.push_back(e);
                end
            end
        end
        rdy_after = ((DEPTH - wq.size()) >= LANES);
        ebus = 140'd0;
        n = (wq.size() < ports) ? wq.size() : ports;
        for (int p = 0; p < n; p++)
            ebus[70*(ports-1-p) +: 70] = {wq[p].pc, 1'b1, wq[p].dest, wq[p].data};
`ifdef WB_SAME_DEST_FILTER_EN
        for (int p = 0; p < n; p++)
            for (int k = p + 1; k < n; k++)
                if (wq[k].dest == wq[p].dest) ebus[70*(ports-1-p)+37] = 1'b0;
`endif
    endtask

    task automatic drive(input logic [3:0] v, input logic [139:0] b);
        exp_t e;
        logic r0, r1;
        logic [139:0] b0, b1;
        @(negedge clk);
        es_to_ws_valid = v;
        es_to_ws_bus   = b;
        wq = mq0; model_step(2, acc0, r0, b0); mq0 = wq;
        wq = mq1; model_step(1, acc1, r1, b1); mq1 = wq;
        e.rdy0 = r0; e.rdy1 = r1; e.bus0 = b0; e.bus1 = b1;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (mq0.size() != 0 || mq1.size() != 0 || i < 1) drive(4'd0, 140'd0);
        end
    endtask

    task automatic reset_checks(input string tag);
        check_bit({tag, "_we_d0p0"}, bus0[107], 1'b0);
        check_bit({tag, "_we_d0p1"}, bus0[37], 1'b0);
        check_bit({tag, "_we_d1p0"}, bus1[37], 1'b0);
        check_bit({tag, "_ready0"}, rdy0, 1'b1);
        check_bit({tag, "_ready1"}, rdy1, 1'b1);
    endtask

    // Monitor: compare each post-edge DUT state with the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_bit("ready0", rdy0, e.rdy0);
                check_bus("dut0", 2, bus0, e.bus0);
                check_bit("ready1", rdy1, e.rdy1);
                check_bus("dut1", 1, {70'd0, bus1}, e.bus1);
            end
        end
    end

    initial begin
        logic [3:0]   v;
        logic [139:0] b;
        int           tries;

        repeat (3) @(negedge clk);
        reset_checks("por");
        reset = 1'b1;

        repeat (10) drive(4'd0, 140'd0);

        drive(4'b1111, {mk(1'b1, 5'd4, 32'h22, 32'h1c000004), mk(1'b1, 5'd3, 32'h11, 32'h1c000000)});
        drain();
        drive(4'b1111, {mk(1'b1, 5'd5, 32'hB, 32'h1c000014), mk(1'b1, 5'd5, 32'hA, 32'h1c000010)});
        drain();
        drive(4'b1110, {mk(1'b1, 5'd0, 32'h33, 32'h1c000024), mk(1'b1, 5'd7, 32'h44, 32'h1c000020)});
        drain();

        // Three full bundles; the 1-port instance back-pressures and the bundle is held
        for (int k = 0; k < 3; k++) begin
            b = {mk(1'b1, 5'(2*k+2), 32'(100+2*k+1), 32'h1c000104 + 32'(8*k)),
                 mk(1'b1, 5'(2*k+1), 32'(100+2*k), 32'h1c000100 + 32'(8*k))};
            tries = 0;
            do begin
                drive(4'b1111, b);
                tries++;
            end while (!acc1 && tries < 6);
            if (!acc1) begin
                vectors++;
                miscompares++;
                $display("FAIL hold_bound: bundle %0d not accepted after %0d cycles", k, tries);
            end
        end
        drain();

        // Mid-stream reset with three entries queued in the 1-port instance
        drive(4'b1111, {mk(1'b1, 5'd9, 32'h99, 32'h1c000204), mk(1'b1, 5'd8, 32'h88, 32'h1c000200)});
        drive(4'b1111, {mk(1'b1, 5'd11, 32'hBB, 32'h1c00020c), mk(1'b1, 5'd10, 32'hAA, 32'h1c000208)});
        @(negedge clk);
        reset = 1'b0;
        es_to_ws_valid = 4'd0;
        es_to_ws_bus = 140'd0;
        #1;
        reset_checks("midrst");
        mq0.delete();
        mq1.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) drive(4'd0, 140'd0);

        // Randomized traffic; hold the bundle while the 1-port model is not ready
        v = 4'd0;
        b = 140'd0;
        for (int c = 0; c < 400; c++) begin
            if (acc1) begin
                for (int l = 0; l < LANES; l++) begin
                    v[2*l +: 2] = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
                    b[70*l +: 70] = mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 4)),
                                       $urandom, 32'h1c000000 + 32'(4*c + l));
                end
            end
            drive(v, b);
        end
        drain();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: %0d expectations left, 0 required", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
